// File: rtl/clk_ratio_pkg.sv
// Shared types and constants for the clock ratio meter and its helpers.
package clk_ratio_pkg;

    // Measurement controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } meter_state_t;

    // Number of flops in the metastability synchronizer.
    localparam int SYNC_DEPTH = 2;

    // Largest supported log2 of the averaging window.
    localparam int MAX_AVG_LOG2 = 4;

endpackage : clk_ratio_pkg

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Produces a single-cycle pulse per rising edge of an asynchronous input;
// also suitable for conditioning a UART RX line.
module sync_edge_det
    import clk_ratio_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_edge
);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic                  edge_q, edge_d;

    // Next-state: shift the input through the synchronizer and compare
    // the synchronized value against its previous sample.
    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], i_d};
        prev_d = sync_q[SYNC_DEPTH-1];
        edge_d = sync_q[SYNC_DEPTH-1] & ~prev_q;
    end

    // Synchronizer, history and edge pulse registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign o_edge = edge_q;

endmodule : sync_edge_det

// File: rtl/clk_ratio_meter.sv
// Measures the period of an asynchronous square wave in reference-clock
// cycles, averaged over 2^AVG_LOG2 periods. The result can be fed straight
// into a clock divider as its ratio. AVG_LOG2 is expected in 0..MAX_AVG_LOG2.
module clk_ratio_meter
    import clk_ratio_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_meas_en,
    input  logic             i_sig,
    output logic [WIDTH-1:0] o_ratio,
    output logic             o_valid,
    output logic             o_ovf,
    output logic             o_busy
);

    // The accumulator holds up to 2^AVG_LOG2 periods of at most 2^WIDTH-1
    // cycles each, so WIDTH+AVG_LOG2 bits never overflow.
    localparam int ACC_W  = WIDTH + AVG_LOG2;
    // Keep the period index at least one bit wide so AVG_LOG2=0 still builds.
    localparam int PIDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [WIDTH-1:0]  PCNT_MAX  = '1;
    localparam logic [WIDTH-1:0]  PCNT_ONE  = WIDTH'(1);

    logic                sig_edge;

    meter_state_t        state_q, state_d;
    logic [WIDTH-1:0]    pcnt_q,  pcnt_d;
    logic [ACC_W-1:0]    acc_q,   acc_d;
    logic [PIDX_W-1:0]   pidx_q,  pidx_d;
    logic [WIDTH-1:0]    ratio_q, ratio_d;
    logic                valid_q, valid_d;
    logic                ovf_q,   ovf_d;

    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_avg;

    sync_edge_det u_sync_edge_det (
        .i_clk  (i_ref_clk),
        .i_rst  (i_rst),
        .i_d    (i_sig),
        .o_edge (sig_edge)
    );

    // Sum including the period that is closing right now, and its
    // truncating average over the window.
    always_comb begin
        acc_sum = acc_q + ACC_W'(pcnt_q);
        acc_avg = acc_sum >> AVG_LOG2;
    end

    // Controller: next state, period counting, accumulation and result update.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        acc_d   = acc_q;
        pidx_d  = pidx_q;
        ratio_d = ratio_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                pcnt_d = '0;
                acc_d  = '0;
                pidx_d = '0;
                if (i_meas_en) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (!i_meas_en) begin
                    state_d = ST_IDLE;
                end else if (sig_edge) begin
                    pcnt_d  = PCNT_ONE;
                    acc_d   = '0;
                    pidx_d  = '0;
                    state_d = ST_COUNT;
                end
            end

            ST_COUNT: begin
                // Disable takes priority over a coincident edge.
                if (!i_meas_en) begin
                    state_d = ST_IDLE;
                end else if (sig_edge) begin
                    pcnt_d = PCNT_ONE;
                    if (pidx_q == PIDX_LAST) begin
                        ratio_d = acc_avg[WIDTH-1:0];
                        valid_d = 1'b1;
                        ovf_d   = 1'b0;
                        pidx_d  = '0;
                        acc_d   = '0;
                    end else begin
                        acc_d  = acc_sum;
                        pidx_d = pidx_q + PIDX_W'(1);
                    end
                end else if (pcnt_q == PCNT_MAX) begin
                    // Period too long to count: flag it, saturate the
                    // reported ratio and re-arm on the next edge.
                    ovf_d   = 1'b1;
                    ratio_d = '1;
                    pcnt_d  = '0;
                    acc_d   = '0;
                    pidx_d  = '0;
                    state_d = ST_ARM;
                end else begin
                    pcnt_d = pcnt_q + PCNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller, counter and output registers.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            acc_q   <= '0;
            pidx_q  <= '0;
            ratio_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            acc_q   <= acc_d;
            pidx_q  <= pidx_d;
            ratio_q <= ratio_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ratio = ratio_q;
    assign o_valid = valid_q;
    assign o_ovf   = ovf_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule : clk_ratio_meter

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

- Measures the period of an asynchronous slow clock (or any periodic square wave, e.g. a UART autobaud reference) in units of `i_ref_clk` cycles.
- Averages the period over 2^AVG_LOG2 periods and reports the ratio, which is directly usable as a clock-divider ratio input.
- Sits beside the clock divider in the UART system: the divider turns a ratio into a clock; this block turns a clock back into a ratio. This supports autobaud and divider self-check.

## Interface
- `WIDTH`, 8: ratio width; the maximum measurable period is 2^WIDTH-1 cycles.
- `AVG_LOG2`, 2: log2 of the number of periods averaged, range 0..4.
- `i_ref_clk`  in  1: reference clock, rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_meas_en`  in  1: measurement enable, level sensitive.
- `i_sig`  in  1: asynchronous signal under measurement.
- `o_ratio`  out  WIDTH: last averaged period in ref cycles; held between updates.
- `o_valid`  out  1: one-cycle pulse when `o_ratio` updates with a good measurement.
- `o_ovf`  out  1: sticky flag, period exceeded the counter range; cleared by the next `o_valid`.
- `o_busy`  out  1: high in ARM and COUNT.

## Operation
- `i_sig` passes through a 2-FF synchronizer, then a rising-edge detector, producing a one-cycle `edge` pulse.
- FSM states: IDLE, ARM, COUNT.
- IDLE:
  - Counters are cleared.
  - Go to ARM when `i_meas_en`=1.
- ARM:
  - Wait for `edge`.
  - On `edge`: period counter `pcnt`←1, accumulator `acc`←0, period index `pidx`←0, go to COUNT.
- COUNT, no `edge`: `pcnt`←`pcnt`+1 each cycle.
- COUNT, on `edge`:
  - `acc`←`acc`+`pcnt`, `pcnt`←1, `pidx`←`pidx`+1.
  - If `pidx` was 2^AVG_LOG2-1: `o_ratio`←(`acc`+`pcnt`)>>AVG_LOG2 (truncating), `o_valid`←1, `o_ovf`←0, `pidx`←0, `acc`←0.
  - Stay in COUNT (continuous mode); the closing edge of one measurement is the opening edge of the next.
- Width rules:
  - `pcnt` is WIDTH bits.
  - `acc` is WIDTH+AVG_LOG2 bits and cannot overflow.
- Overflow: in COUNT, if `pcnt`=2^WIDTH-1 and no `edge` arrives that cycle:
  - `o_ovf`←1, `o_ratio`←all ones, `o_valid` not pulsed.
  - Go to ARM and discard the partial accumulation.
- `i_meas_en` low in ARM or COUNT:
  - Go to IDLE next cycle.
  - No `o_valid`; `o_ratio` and `o_ovf` keep their values.
- Simultaneous `edge` and `i_meas_en` falling: the disable wins and nothing is accumulated.
- Minimum measurable period is 2 (`i_sig` toggling every ref cycle). Periods below 2 alias and are out of scope.

## Timing
- Reset values: `o_ratio`=0, `o_valid`=0, `o_ovf`=0, `o_busy`=0, FSM=IDLE, all counters 0.
- `edge` is asserted 3 ref cycles after the first `i_ref_clk` edge that samples `i_sig` high (2 sync + 1 detect).
- `o_valid` and the new `o_ratio` appear 1 cycle after the `edge` that closes the final averaged period.
- First result after enable: 2^AVG_LOG2 periods + ARM wait + 4 cycles.
- Continuous mode gives one `o_valid` every 2^AVG_LOG2 periods with no gaps.
- `o_busy` rises 1 cycle after `i_meas_en` rises and falls 1 cycle after `i_meas_en` falls.
- Reset asserted mid-COUNT clears everything immediately. After release, measurement restarts from ARM only if `i_meas_en`=1.

## Structure
- Shared package `clk_ratio_pkg`:
  - FSM state enum (IDLE, ARM, COUNT).
  - Constants for sync depth (2) and maximum AVG_LOG2 (4).
- Sub-module `sync_edge_det`: 2-FF synchronizer plus rising-edge pulse, reset to 0. It is reusable for the UART RX line.
- Top level holds the FSM, `pcnt`, `acc`, `pidx` and output registers.

## Test plan
- WIDTH=8, AVG_LOG2=2, `i_sig` period 10 (5 high / 5 low), enable held → first `o_valid` with `o_ratio`=10, then one `o_valid` every 40 cycles; `o_ovf`=0.
- Periods alternating 9 and 10 → `acc`=38 → `o_ratio`=9 (truncation check).
- `i_sig` period 2 → `o_ratio`=2; AVG_LOG2=0 with period 255 → `o_ratio`=255, no overflow.
- `i_sig` held low after one edge → 255 cycles later `o_ovf`=1, `o_ratio`=255, no `o_valid`. Then period 20 resumes → `o_ratio`=20, `o_valid` pulses, `o_ovf` clears.
- Drop `i_meas_en` mid-COUNT → IDLE next cycle, `o_busy`=0, no `o_valid`, `o_ratio` unchanged. Re-enable → fresh ARM result.
- Assert `i_rst` asynchronously mid-COUNT → all outputs 0 immediately. Release with enable high → correct ratio after a full averaging window.
